// File: rtl/proc_pkg.sv
// proc_pkg: shared opcodes, FSM state encoding and instruction byte layout for proc_core
package proc_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} state_t;
  localparam logic [7:0] OP_NOP  = 8'd0;
  localparam logic [7:0] OP_MOVI = 8'd1;
  localparam logic [7:0] OP_LDB  = 8'd2;
  localparam logic [7:0] OP_STB  = 8'd3;
  localparam logic [7:0] OP_ADD  = 8'd4;
  localparam logic [7:0] OP_SUB  = 8'd5;
  localparam logic [7:0] OP_JMP  = 8'd6;
  localparam logic [7:0] OP_JZ   = 8'd7;
  localparam logic [7:0] OP_HALT = 8'd8;
  localparam int OFF_OP      = 0;
  localparam int OFF_RSEL    = 1;
  localparam int OFF_LO      = 2;
  localparam int OFF_HI      = 3;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: register file, two async read ports, one sync write port, r0/r1 taps
// ports: clk, reset (async, clears all entries), we/wa/wd write port,
//        ra/qa and rb/qb read ports, r0/r1 direct taps of entries 0 and 1
module proc_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS = 16,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [RW-1:0]         wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [RW-1:0]         ra,
  input  logic [RW-1:0]         rb,
  output logic [DATA_WIDTH-1:0] qa,
  output logic [DATA_WIDTH-1:0] qb,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  assign qa = regs[ra];
  assign qb = regs[rb];
  assign r0 = regs[0];
  assign r1 = regs[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we) regs[wa] <= wd;
endmodule

// File: rtl/proc_core.sv
// proc_core: multi-cycle byte-RAM processor core, FETCH/EXEC per instruction
// ports: clk, reset (async); load_en/load_addr/load_data byte load port (IDLE/HALT only);
//        start pulse; dbg_addr -> dbg_data registered RAM read; ipointer, opcode,
//        r0/r1 register mirrors; running/halted status; sticky error on illegal opcode
module proc_core
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [7:0]            dbg_data,
  output logic [ADDR_WIDTH-1:0] ipointer,
  output logic [7:0]            opcode,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1,
  output logic                  running,
  output logic                  halted,
  output logic                  error
);
  localparam int RW = $clog2(NUM_REGS);
  logic [7:0] ram [2**ADDR_WIDTH];
  state_t state;
  logic [RW-1:0] rd, ra_idx, rb_idx;
  logic [15:0] k, fk;
  logic [7:0] mem_byte, ram_wd;
  logic [DATA_WIDTH-1:0] rd_val, rs_val, qa, qb, tap0, tap1, wd;
  logic [ADDR_WIDTH-1:0] ip_op, ip_rsel, ip_lo, ip_hi, ip_next, addr, ram_addr;
  logic idle, we, ram_we;
  assign ip_op = ipointer + ADDR_WIDTH'(OFF_OP);
  assign ip_rsel = ipointer + ADDR_WIDTH'(OFF_RSEL);
  assign ip_lo = ipointer + ADDR_WIDTH'(OFF_LO);
  assign ip_hi = ipointer + ADDR_WIDTH'(OFF_HI);
  assign ip_next = ipointer + ADDR_WIDTH'(INSTR_BYTES);
  assign fk = {ram[ip_hi], ram[ip_lo]};
  assign ra_idx = ram[ip_rsel][RW-1:0];
  assign rb_idx = ram[ip_lo][RW-1:0];
  assign addr = ADDR_WIDTH'(k);
  assign idle = state == ST_IDLE || state == ST_HALT;
  assign running = state == ST_FETCH || state == ST_EXEC;
  assign halted = state == ST_HALT;
  assign we = state == ST_EXEC &&
              (opcode == OP_MOVI || opcode == OP_LDB || opcode == OP_ADD || opcode == OP_SUB);
  assign wd = opcode == OP_MOVI ? DATA_WIDTH'(k) :
              opcode == OP_LDB  ? DATA_WIDTH'(mem_byte) :
              opcode == OP_ADD  ? rd_val + rs_val : rd_val - rs_val;
  // the load port and STB never compete: loads only while idle, STB only in EXEC
  assign ram_we = (state == ST_EXEC && opcode == OP_STB) || (idle && load_en);
  assign ram_addr = idle ? load_addr : addr;
  assign ram_wd = idle ? load_data : rd_val[7:0];
  proc_regfile #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .reset(reset), .we(we), .wa(rd), .wd(wd),
    .ra(ra_idx), .rb(rb_idx), .qa(qa), .qb(qb), .r0(tap0), .r1(tap1)
  );
  always_ff @(posedge clk)
    if (ram_we) ram[ram_addr] <= ram_wd;
  always_ff @(posedge clk or posedge reset)
    dbg_data <= reset ? 8'h00 : ram[dbg_addr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ipointer <= '0;
      opcode <= '0;
      rd <= '0;
      k <= '0;
      mem_byte <= '0;
      rd_val <= '0;
      rs_val <= '0;
      r0 <= '0;
      r1 <= '0;
      error <= 1'b0;
    end else begin
      r0 <= tap0;
      r1 <= tap1;
      case (state)
        ST_FETCH: begin
          opcode <= ram[ip_op];
          rd <= ra_idx;
          k <= fk;
          mem_byte <= ram[ADDR_WIDTH'(fk)];
          rd_val <= qa;
          rs_val <= qb;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          ipointer <= ip_next;
          if (opcode == OP_JMP || (opcode == OP_JZ && rd_val == '0)) ipointer <= addr;
          if (opcode == OP_HALT) begin
            state <= ST_HALT;
            ipointer <= ipointer;
          end
          if (opcode > OP_HALT) begin
            state <= ST_HALT;
            error <= 1'b1;
          end
        end
        default: if (start) begin
          state <= ST_FETCH;
          ipointer <= '0;
          error <= 1'b0;
        end
      endcase
    end
  end
endmodule
